// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer. It issues one registered control
// word per clock to the ALU, the datapath registers and memory.
//
//  state | meaning
//  IDLE  | waiting for run
//  F1    | MAR <- PC
//  F2    | PC+1, MBR <- M[MAR]
//  F3    | IR <- MBR
//  DEC   | decode ir_opcode (word 0)
//  E1-E5 | execute steps; the word depends on the latched instruction kind
//  HALT  | sticky stop, left only through reset
module control_sequencer #(
  parameter int CNT_W      = 16,
  parameter int RESET_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [7:0]       ir_opcode,
  input  logic [7:0]       flag,
  output logic [31:0]      control_signal,
  output logic             halted,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_F1 = 4'd1, S_F2 = 4'd2, S_F3 = 4'd3, S_DEC = 4'd4,
    S_E1 = 4'd5, S_E2 = 4'd6, S_E3 = 4'd7, S_E4 = 4'd8, S_E5 = 4'd9,
    S_HALT = 4'd15
  } state_t;

  typedef enum logic [2:0] {K_NONE, K_STORE, K_LOAD, K_BIN, K_JMP} kind_t;

  localparam logic [31:0] C_MAR_PC  = 32'h0000_0001;
  localparam logic [31:0] C_PC_INC  = 32'h0000_0002;
  localparam logic [31:0] C_RD      = 32'h0000_0004;
  localparam logic [31:0] C_IR      = 32'h0000_0008;
  localparam logic [31:0] C_MAR_IR  = 32'h0000_0010;
  localparam logic [31:0] C_BR      = 32'h0000_0020;
  localparam logic [31:0] C_MBR_ACC = 32'h0000_0040;
  localparam logic [31:0] C_WR      = 32'h0000_0080;
  localparam logic [31:0] C_PC_IR   = 32'h0000_0100;
  localparam logic [31:0] C_ACC_MBR = 32'h0000_0200;
  localparam logic [31:0] C_MR      = 32'h0001_0000;
  localparam logic [31:0] C_ADD     = 32'h0040_0000;
  localparam logic [31:0] C_SUB     = 32'h0080_0000;
  localparam logic [31:0] C_AND     = 32'h0100_0000;
  localparam logic [31:0] C_OR      = 32'h0200_0000;
  localparam logic [31:0] C_NOT     = 32'h0400_0000;
  localparam logic [31:0] C_SHL     = 32'h0800_0000;
  localparam logic [31:0] C_SHR     = 32'h1000_0000;
  localparam logic [31:0] C_MPY     = 32'h2000_0000;
  localparam logic [31:0] C_SAL     = 32'h4000_0000;
  localparam logic [31:0] C_SAR     = 32'h8000_0000;

  state_t      state, state_nxt;
  kind_t       kind, kind_nxt;
  logic [31:0] op_bits, op_nxt;
  logic        jmp_take, take_nxt;
  logic [31:0] ctrl_nxt;
  logic        finish, bump;

  // Only flag[0] (ACC negative) steers the sequencer.
  logic unused_flag;
  assign unused_flag = ^flag[7:1];

  // State, latched decode and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      kind           <= K_NONE;
      op_bits        <= '0;
      jmp_take       <= 1'b0;
      control_signal <= '0;
      instr_count    <= '0;
    end else begin
      state          <= state_nxt;
      kind           <= kind_nxt;
      op_bits        <= op_nxt;
      jmp_take       <= take_nxt;
      control_signal <= ctrl_nxt;
      if (bump) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next state, decode, and the control word for the state being entered.
  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    op_nxt    = op_bits;
    take_nxt  = jmp_take;
    finish    = 1'b0;
    bump      = 1'b0;
    case (state)
      S_IDLE: if (run || RESET_IDLE == 0) state_nxt = S_F1;
      S_F1:   state_nxt = S_F2;
      S_F2:   state_nxt = S_F3;
      S_F3:   state_nxt = S_DEC;
      S_DEC: begin
        kind_nxt = K_NONE;
        op_nxt   = '0;
        take_nxt = 1'b0;
        case (ir_opcode)
          8'h01: begin kind_nxt = K_STORE; state_nxt = S_E1; end
          8'h02: begin kind_nxt = K_LOAD;  state_nxt = S_E1; end
          8'h03: begin kind_nxt = K_BIN; op_nxt = C_ADD;        state_nxt = S_E1; end
          8'h04: begin kind_nxt = K_BIN; op_nxt = C_SUB;        state_nxt = S_E1; end
          8'h08: begin kind_nxt = K_BIN; op_nxt = C_MPY | C_MR; state_nxt = S_E1; end
          8'h0A: begin kind_nxt = K_BIN; op_nxt = C_AND;        state_nxt = S_E1; end
          8'h0B: begin kind_nxt = K_BIN; op_nxt = C_OR;         state_nxt = S_E1; end
          8'h0C: begin op_nxt = C_NOT; state_nxt = S_E4; end
          8'h0D: begin op_nxt = C_SHR; state_nxt = S_E4; end
          8'h0E: begin op_nxt = C_SHL; state_nxt = S_E4; end
          8'h0F: begin op_nxt = C_SAL; state_nxt = S_E4; end
          8'h10: begin op_nxt = C_SAR; state_nxt = S_E4; end
          8'h06: begin kind_nxt = K_JMP; take_nxt = 1'b1;     state_nxt = S_E1; end
          8'h05: begin kind_nxt = K_JMP; take_nxt = ~flag[0]; state_nxt = S_E1; end
          8'h07: begin state_nxt = S_HALT; bump = 1'b1; end
          default: finish = 1'b1;
        endcase
      end
      S_E1:   if (kind == K_JMP) finish = 1'b1; else state_nxt = S_E2;
      S_E2:   state_nxt = S_E3;
      S_E3:   if (kind == K_BIN) state_nxt = S_E4; else finish = 1'b1;
      S_E4:   state_nxt = S_E5;
      S_E5:   finish = 1'b1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (finish) begin
      bump      = 1'b1;
      state_nxt = run ? S_F1 : S_IDLE;
    end

    ctrl_nxt = '0;
    case (state_nxt)
      S_F1: ctrl_nxt = C_MAR_PC;
      S_F2: ctrl_nxt = C_PC_INC | C_RD;
      S_F3: ctrl_nxt = C_IR;
      S_E1: ctrl_nxt = (kind_nxt == K_JMP) ? (take_nxt ? C_PC_IR : '0) : C_MAR_IR;
      S_E2: ctrl_nxt = (kind_nxt == K_STORE) ? C_MBR_ACC : C_RD;
      S_E3: ctrl_nxt = (kind_nxt == K_STORE) ? C_WR :
                       (kind_nxt == K_LOAD)  ? C_ACC_MBR : C_BR;
      S_E4, S_E5: ctrl_nxt = op_nxt;
      default: ctrl_nxt = '0;
    endcase
  end

  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule
